// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
// Produces HSYNC/VSYNC with configurable porches and polarity, data-enable,
// active-area pixel coordinates and line/frame strobes, with run/stop control
// that only stops on a frame boundary.
// All outputs are registered from the same next-position decode, so in any
// cycle every output describes the presented (HCNT, VCNT) position.
// Optional feature: define VGA_TIMING_GEN_FRAME_CNT_EN to enable the 16-bit
// FRAME_CNT counter; otherwise FRAME_CNT is tied to zero.

module vga_timing_gen #(
  parameter int unsigned CNT_W  = 12,
  parameter int unsigned H_SYNC = 112,
  parameter int unsigned H_BP   = 248,
  parameter int unsigned H_ACT  = 1280,
  parameter int unsigned H_FP   = 48,
  parameter int unsigned V_SYNC = 3,
  parameter int unsigned V_BP   = 38,
  parameter int unsigned V_ACT  = 1024,
  parameter int unsigned V_FP   = 1,
  parameter bit          H_POL  = 1'b1,
  parameter bit          V_POL  = 1'b1
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             RUN,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic             DE,
  output logic [CNT_W-1:0] PIX_X,
  output logic [CNT_W-1:0] PIX_Y,
  output logic [CNT_W-1:0] HCNT,
  output logic [CNT_W-1:0] VCNT,
  output logic             LINE_START,
  output logic             FRAME_START,
  output logic             BUSY,
  output logic [15:0]      FRAME_CNT
);

  // Raster geometry; both totals must fit in CNT_W bits.
  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_DE_BEG   = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_DE_END   = CNT_W'(H_SYNC + H_BP + H_ACT);
  localparam logic [CNT_W-1:0] V_DE_BEG   = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_DE_END   = CNT_W'(V_SYNC + V_BP + V_ACT);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hcnt, vcnt;
  logic [CNT_W-1:0] hcnt_nxt, vcnt_nxt;
  logic             h_wrap, v_wrap, frame_end;

  logic             busy_nxt;
  logic             h_in_act, v_in_act;
  logic             hsync_nxt, vsync_nxt, de_nxt;
  logic [CNT_W-1:0] pix_x_nxt, pix_y_nxt;
  logic             line_start_nxt, frame_start_nxt;

  // Next state and next raster position.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_nxt = state;
    hcnt_nxt  = hcnt;
    vcnt_nxt  = vcnt;
    h_wrap    = (hcnt == H_LAST);
    v_wrap    = (vcnt == V_LAST);
    frame_end = h_wrap && v_wrap;

    case (state)
      ST_IDLE: begin
        hcnt_nxt = '0;
        vcnt_nxt = '0;
        if (RUN) begin
          state_nxt = ST_RUN;
        end
      end

      ST_RUN, ST_STOPPING: begin
        if (frame_end && !RUN) begin
          // Last position of the frame presented with no run request: stop
          // cleanly on the frame boundary.
          state_nxt = ST_IDLE;
          hcnt_nxt  = '0;
          vcnt_nxt  = '0;
        end else begin
          // RUN only selects between RUN and STOPPING; the raster itself is
          // never disturbed, so re-asserting RUN while stopping is seamless.
          state_nxt = RUN ? ST_RUN : ST_STOPPING;
          hcnt_nxt  = h_wrap ? '0 : hcnt + 1'b1;
          if (h_wrap) begin
            vcnt_nxt = v_wrap ? '0 : vcnt + 1'b1;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        hcnt_nxt  = '0;
        vcnt_nxt  = '0;
      end
    endcase
  end

  // Region decode of the next position, registered below alongside it.
  always_comb begin
    busy_nxt        = (state_nxt != ST_IDLE);
    h_in_act        = (hcnt_nxt >= H_DE_BEG) && (hcnt_nxt < H_DE_END);
    v_in_act        = (vcnt_nxt >= V_DE_BEG) && (vcnt_nxt < V_DE_END);
    hsync_nxt       = (busy_nxt && (hcnt_nxt < H_SYNC_END)) ? H_POL : ~H_POL;
    vsync_nxt       = (busy_nxt && (vcnt_nxt < V_SYNC_END)) ? V_POL : ~V_POL;
    de_nxt          = busy_nxt && h_in_act && v_in_act;
    pix_x_nxt       = de_nxt ? (hcnt_nxt - H_DE_BEG) : '0;
    pix_y_nxt       = de_nxt ? (vcnt_nxt - V_DE_BEG) : '0;
    line_start_nxt  = busy_nxt && (hcnt_nxt == '0);
    frame_start_nxt = line_start_nxt && (vcnt_nxt == '0);
  end

  // State, position and all decoded outputs, updated together.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state       <= ST_IDLE;
      hcnt        <= '0;
      vcnt        <= '0;
      HSYNC       <= ~H_POL;
      VSYNC       <= ~V_POL;
      DE          <= 1'b0;
      PIX_X       <= '0;
      PIX_Y       <= '0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      state       <= state_nxt;
      hcnt        <= hcnt_nxt;
      vcnt        <= vcnt_nxt;
      HSYNC       <= hsync_nxt;
      VSYNC       <= vsync_nxt;
      DE          <= de_nxt;
      PIX_X       <= pix_x_nxt;
      PIX_Y       <= pix_y_nxt;
      LINE_START  <= line_start_nxt;
      FRAME_START <= frame_start_nxt;
      BUSY        <= busy_nxt;
    end
  end

  assign HCNT = hcnt;
  assign VCNT = vcnt;

`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
  // Count frame strobes; the new value shows from the cycle after the strobe
  // and is held through IDLE.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      FRAME_CNT <= 16'd0;
    end else if (FRAME_START) begin
      FRAME_CNT <= FRAME_CNT + 16'd1;
    end
  end
`else
  assign FRAME_CNT = 16'd0;
`endif

endmodule
